// File: rtl/axis_pkt_checker.sv
// axis_pkt_checker: AXI-Stream sink that checks a running seq payload and framing, throttles tready, counts packets.
// Ports: clk, rst_n (async active-low, deassertion synchronised internally);
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast stream sink, s_tready registered;
//   cfg_en checker enable, cfg_ready_mask tready rotation pattern (8'hFF = always ready), clr clear pulse;
//   pkt_cnt/err_cnt saturating counters, err_flags sticky {length, keep, data}, busy while in MID or RESYNC.
// Optional: define AXIS_PKT_CHECKER_SEED_EN to add cfg_seed, the seq value loaded on reset release and clr.
module axis_pkt_checker #(
  parameter int TDATA_WIDTH   = 32,
  parameter int TKEEP_WIDTH   = TDATA_WIDTH / 8,
  parameter int MAX_PKT_BEATS = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic                   cfg_en,
  input  logic [7:0]             cfg_ready_mask,
`ifdef AXIS_PKT_CHECKER_SEED_EN
  input  logic [31:0]            cfg_seed,
`endif
  input  logic                   clr,
  output logic [CNT_WIDTH-1:0]   pkt_cnt,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  output logic [2:0]             err_flags,
  output logic                   busy
);
  localparam logic [1:0] OFF    = 2'd0;
  localparam logic [1:0] SOP    = 2'd1;
  localparam logic [1:0] MID    = 2'd2;
  localparam logic [1:0] RESYNC = 2'd3;
  localparam int LANES = TDATA_WIDTH / 32;
  localparam int BW    = $clog2(MAX_PKT_BEATS + 1);

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_int_n;
  logic [1:0]             state_q, state_d, idle;
  logic [7:0]             rot_q, rot_d;
  logic                   tready_q, tready_d;
  logic [31:0]            seq_q, seq_d, seq_base;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic                   pkt_derr_q, pkt_derr_d, pkt_kerr_q, pkt_kerr_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d, pc, ec;
  logic [2:0]             flags_q, flags_d;
  logic [TDATA_WIDTH-1:0] keep_mask;
  logic                   beat, chk, d_err, k_err, pkt_end, len_err, fin, seq_load;
`ifdef AXIS_PKT_CHECKER_SEED_EN
  logic                   init_q, init_d;
`endif

  // Reset asserts asynchronously but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    keep_mask = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) keep_mask[8*i +: 8] = {8{s_tkeep[i]}};
    beat = s_tvalid && tready_q;
    chk = beat && (state_q == SOP || state_q == MID);
    // d_err/k_err are the packet's accumulated error including the current beat.
    d_err = pkt_derr_q | (chk && |((s_tdata ^ {LANES{seq_q}}) & keep_mask));
    k_err = pkt_kerr_q | (chk && (s_tlast ? (s_tkeep == '0 || (s_tkeep & (s_tkeep + TKEEP_WIDTH'(1))) != '0)
                                          : s_tkeep != '1));
    pkt_end = chk && s_tlast;
    len_err = chk && !s_tlast && beat_cnt_q == BW'(MAX_PKT_BEATS - 1);
    fin = pkt_end || len_err;
    idle = cfg_en ? SOP : OFF;
    state_d = state_q == OFF      ? idle
            : (beat && s_tlast)   ? idle
            : len_err             ? RESYNC
            : state_q == SOP      ? (beat ? MID : idle)
            : state_q;
    rot_d = (state_q == OFF && cfg_en) ? cfg_ready_mask : {rot_q[0], rot_q[7:1]};
    // Using the next state keeps tready low the moment a packet ends into OFF.
    tready_d = state_d != OFF && rot_d[0];
    beat_cnt_d = chk ? (fin ? '0 : beat_cnt_q + BW'(1)) : beat_cnt_q;
    pkt_derr_d = fin ? 1'b0 : d_err;
    pkt_kerr_d = fin ? 1'b0 : k_err;
`ifdef AXIS_PKT_CHECKER_SEED_EN
    init_d = 1'b0;
    seq_load = clr || init_q;
    seq_base = cfg_seed;
`else
    seq_load = clr;
    seq_base = '0;
`endif
    seq_d = seq_load ? seq_base : seq_q + 32'(beat);
    // clr clears first, so a packet ending in the clr cycle lands on the cleared values.
    flags_d = (clr ? 3'b000 : flags_q) | ({3{fin}} & {len_err, k_err, d_err});
    pc = clr ? '0 : pkt_cnt_q;
    ec = clr ? '0 : err_cnt_q;
    pkt_cnt_d = pc + CNT_WIDTH'(pkt_end && !d_err && !k_err && pc != '1);
    err_cnt_d = ec + CNT_WIDTH'(fin && (len_err || d_err || k_err) && ec != '1);
  end

  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      state_q    <= OFF;
      rot_q      <= '0;
      tready_q   <= 1'b0;
      seq_q      <= '0;
      beat_cnt_q <= '0;
      pkt_derr_q <= 1'b0;
      pkt_kerr_q <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      flags_q    <= '0;
`ifdef AXIS_PKT_CHECKER_SEED_EN
      init_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rot_q      <= rot_d;
      tready_q   <= tready_d;
      seq_q      <= seq_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_derr_q <= pkt_derr_d;
      pkt_kerr_q <= pkt_kerr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      flags_q    <= flags_d;
`ifdef AXIS_PKT_CHECKER_SEED_EN
      init_q     <= init_d;
`endif
    end

  assign s_tready  = tready_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_flags = flags_q;
  assign busy      = state_q[1];
endmodule
